// File: rtl/wb_timer_pkg.sv
// Shared definitions for the Wishbone machine timer: register offsets,
// CTRL layout and a byte-enable merge helper.
package wb_timer_pkg;

  localparam logic [4:0] MTIME_LO_OFS    = 5'h00;
  localparam logic [4:0] MTIME_HI_OFS    = 5'h04;
  localparam logic [4:0] MTIMECMP_LO_OFS = 5'h08;
  localparam logic [4:0] MTIMECMP_HI_OFS = 5'h0C;
  localparam logic [4:0] CTRL_OFS        = 5'h10;
  localparam logic [4:0] PRESCALE_OFS    = 5'h14;

  localparam int unsigned EN_BIT = 0;

  typedef struct packed {
    logic [30:0] rsvd;
    logic        en;
  } ctrl_t;

  // Replace only the bytes whose select bit is set.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) begin
        res[8*i +: 8] = new_val[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_val[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Pipelined Wishbone bus bundle shared by the interconnect, masters and slaves.
interface wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        stall;
  logic        err;

  modport master (output cyc, stb, we, sel, adr, dat_m,
                  input  dat_s, ack, stall, err);
  modport slave  (input  cyc, stb, we, sel, adr, dat_m,
                  output dat_s, ack, stall, err);
endinterface

// File: rtl/wb_timer_prescaler.sv
// Prescaler for the machine timer: emits one tick every PRESCALE+1 enabled
// cycles; a PRESCALE register write restarts the count.
module timer_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_r;
  logic                  wrap_s;

  assign wrap_s = (cnt_r == prescale);
  assign tick   = en & wrap_s;

  // Divide counter; holds while disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      if (wrap_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/wb_timer.sv
// Wishbone slave exposing a RISC-V machine timer (mtime/mtimecmp) with a
// programmable prescaler and a registered level interrupt for Ibex.
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter int unsigned PRESCALE_W   = 16,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic clk,
  input  logic rst_n,
  wb_if.slave  wb,
  output logic irq_timer
);

  logic [63:0]           mtime_r;
  logic [63:0]           mtimecmp_r;
  logic                  en_r;
  logic [PRESCALE_W-1:0] prescale_r;
  logic                  ack_r;
  logic [31:0]           dat_s_r;
  logic                  irq_r;

  logic        accept_s;
  logic        wr_s;
  logic [4:0]  ofs_s;
  logic        wr_mtime_lo_s, wr_mtime_hi_s;
  logic        wr_cmp_lo_s, wr_cmp_hi_s;
  logic        wr_ctrl_s, wr_prescale_s;
  logic        tick_s;
  logic [31:0] rdata_s;
  ctrl_t       ctrl_rd_s;
  logic        unused_adr_s;

  // The interconnect already selected us; only the word index matters.
  assign accept_s     = wb.cyc & wb.stb;
  assign wr_s         = accept_s & wb.we;
  assign ofs_s        = {wb.adr[4:2], 2'b00};
  assign unused_adr_s = ^{wb.adr[31:5], wb.adr[1:0]};

  assign wr_mtime_lo_s = wr_s & (ofs_s == MTIME_LO_OFS);
  assign wr_mtime_hi_s = wr_s & (ofs_s == MTIME_HI_OFS);
  assign wr_cmp_lo_s   = wr_s & (ofs_s == MTIMECMP_LO_OFS);
  assign wr_cmp_hi_s   = wr_s & (ofs_s == MTIMECMP_HI_OFS);
  assign wr_ctrl_s     = wr_s & (ofs_s == CTRL_OFS);
  assign wr_prescale_s = wr_s & (ofs_s == PRESCALE_OFS);

  assign ctrl_rd_s = '{rsvd: 31'd0, en: en_r};

  timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en_r),
    .clr      (wr_prescale_s),
    .prescale (prescale_r),
    .tick     (tick_s)
  );

  // Read data mux; unmapped words read as zero.
  always_comb begin
    rdata_s = 32'd0;
    case (ofs_s)
      MTIME_LO_OFS:    rdata_s = mtime_r[31:0];
      MTIME_HI_OFS:    rdata_s = mtime_r[63:32];
      MTIMECMP_LO_OFS: rdata_s = mtimecmp_r[31:0];
      MTIMECMP_HI_OFS: rdata_s = mtimecmp_r[63:32];
      CTRL_OFS:        rdata_s = ctrl_rd_s;
      PRESCALE_OFS:    rdata_s = 32'(prescale_r);
      default:         rdata_s = 32'd0;
    endcase
  end

  // Bus response: single-cycle ack with data registered at acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_r   <= 1'b0;
      dat_s_r <= 32'd0;
    end else begin
      ack_r <= accept_s;
      if (accept_s) begin
        dat_s_r <= rdata_s;
      end
    end
  end

  // mtime: a bus write beats a tick, and the other half skips the carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtime_r <= 64'd0;
    end else if (wr_mtime_lo_s) begin
      mtime_r[31:0] <= be_merge(mtime_r[31:0], wb.dat_m, wb.sel);
    end else if (wr_mtime_hi_s) begin
      mtime_r[63:32] <= be_merge(mtime_r[63:32], wb.dat_m, wb.sel);
    end else if (tick_s) begin
      mtime_r <= mtime_r + 64'd1;
    end
  end

  // Compare value and control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtimecmp_r <= MTIMECMP_RST;
      en_r       <= 1'b0;
      prescale_r <= '0;
    end else begin
      if (wr_cmp_lo_s) begin
        mtimecmp_r[31:0] <= be_merge(mtimecmp_r[31:0], wb.dat_m, wb.sel);
      end
      if (wr_cmp_hi_s) begin
        mtimecmp_r[63:32] <= be_merge(mtimecmp_r[63:32], wb.dat_m, wb.sel);
      end
      if (wr_ctrl_s && wb.sel[EN_BIT/8]) begin
        en_r <= wb.dat_m[EN_BIT];
      end
      if (wr_prescale_s) begin
        prescale_r <= PRESCALE_W'(be_merge(32'(prescale_r), wb.dat_m, wb.sel));
      end
    end
  end

  // Timer interrupt, independent of EN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= (mtime_r >= mtimecmp_r);
    end
  end

  assign wb.ack    = ack_r;
  assign wb.dat_s  = dat_s_r;
  assign wb.stall  = 1'b0;
  assign wb.err    = 1'b0;
  assign irq_timer = irq_r;

endmodule

// File: tb/tb_wb_timer.sv
// Directed self-checking bench for wb_timer: register access, prescaling,
// interrupt timing, carry/wrap, byte enables, bursts and reset.
module tb_wb_timer;

  logic clk = 1'b0;
  logic rst_n;
  logic irq_timer;
  int   n_checks = 0;
  int   n_fail   = 0;

  wb_if bus ();

  wb_timer #(
    .PRESCALE_W   (16),
    .MTIMECMP_RST (64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb        (bus),
    .irq_timer (irq_timer)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus.cyc   = 1'b0;
    bus.stb   = 1'b0;
    bus.we    = 1'b0;
    bus.sel   = 4'h0;
    bus.adr   = 32'd0;
    bus.dat_m = 32'd0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic bus_write(input logic [31:0] adr, input logic [31:0] data, input logic [3:0] sel);
    bus.cyc   = 1'b1;
    bus.stb   = 1'b1;
    bus.we    = 1'b1;
    bus.adr   = adr;
    bus.dat_m = data;
    bus.sel   = sel;
    @(posedge clk);
    #1;
    bus_idle();
    check_eq("wr_ack", 64'(bus.ack), 64'd1);
  endtask

  task automatic bus_read(input logic [31:0] adr, input logic [31:0] exp, input string tag);
    bus.cyc = 1'b1;
    bus.stb = 1'b1;
    bus.we  = 1'b0;
    bus.adr = adr;
    bus.sel = 4'h0;
    @(posedge clk);
    #1;
    bus_idle();
    check_eq("rd_ack", 64'(bus.ack), 64'd1);
    check_eq(tag, 64'(bus.dat_s), 64'(exp));
  endtask

  task automatic read_reset_values();
    bus_read(32'h00, 32'h0000_0000, "rst_mtime_lo");
    bus_read(32'h04, 32'h0000_0000, "rst_mtime_hi");
    bus_read(32'h08, 32'hFFFF_FFFF, "rst_cmp_lo");
    bus_read(32'h0C, 32'hFFFF_FFFF, "rst_cmp_hi");
    bus_read(32'h10, 32'h0000_0000, "rst_ctrl");
    bus_read(32'h14, 32'h0000_0000, "rst_prescale");
  endtask

  logic [31:0] exp_tick [8];
  logic [31:0] burst_adr [4];
  logic [31:0] burst_exp [4];

  initial begin
    exp_tick  = '{32'd10, 32'd10, 32'd10, 32'd11, 32'd11, 32'd11, 32'd11, 32'd12};
    burst_adr = '{32'h08, 32'h0C, 32'h18, 32'h1C};
    burst_exp = '{32'hFFBB_FFDD, 32'h0, 32'h0, 32'h0};

    // Reset state
    bus_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ack", 64'(bus.ack), 64'd0);
    check_eq("rst_irq", 64'(irq_timer), 64'd0);
    check_eq("rst_dat_s", 64'(bus.dat_s), 64'd0);
    check_eq("stall", 64'(bus.stall), 64'd0);
    check_eq("err", 64'(bus.err), 64'd0);
    rst_n = 1'b1;
    read_reset_values();
    check_eq("irq_idle", 64'(irq_timer), 64'd0);

    // Prescale by 4: first tick 4 edges after EN, then every 4th edge
    bus_write(32'h14, 32'd3, 4'hF);
    bus_write(32'h10, 32'd1, 4'hF);
    repeat (40) @(posedge clk);
    #1;
    bus_read(32'h00, 32'd10, "presc_mtime_40");
    for (int i = 0; i < 8; i++) begin
      bus_read(32'h00, exp_tick[i], "presc_step");
    end
    bus_write(32'h10, 32'd0, 4'hF);
    bus_read(32'h14, 32'd3, "prescale_rb");

    // Interrupt assert/deassert timing
    bus_write(32'h14, 32'd0, 4'hF);
    bus_write(32'h00, 32'd0, 4'hF);
    bus_write(32'h04, 32'd0, 4'hF);
    bus_write(32'h0C, 32'd0, 4'hF);
    bus_write(32'h08, 32'd20, 4'hF);
    check_eq("irq_before", 64'(irq_timer), 64'd0);
    bus_write(32'h10, 32'd1, 4'hF);
    repeat (20) @(posedge clk);
    #1;
    check_eq("irq_at_eq", 64'(irq_timer), 64'd0);
    @(posedge clk);
    #1;
    check_eq("irq_rise", 64'(irq_timer), 64'd1);
    bus_write(32'h08, 32'd1000, 4'hF);
    check_eq("irq_hold", 64'(irq_timer), 64'd1);
    @(posedge clk);
    #1;
    check_eq("irq_fall", 64'(irq_timer), 64'd0);
    bus_write(32'h10, 32'd0, 4'hF);

    // Carry from low into high word
    bus_write(32'h04, 32'd0, 4'hF);
    bus_write(32'h00, 32'hFFFF_FFFF, 4'hF);
    bus_write(32'h10, 32'd1, 4'hF);
    @(posedge clk);
    #1;
    bus_read(32'h04, 32'd1, "carry_hi");
    bus_read(32'h00, 32'd1, "carry_lo");
    bus_write(32'h10, 32'd0, 4'hF);

    // Bus write beats a tick; high half sees no carry
    bus_write(32'h04, 32'd0, 4'hF);
    bus_write(32'h00, 32'hFFFF_FFFF, 4'hF);
    bus_write(32'h10, 32'd1, 4'hF);
    bus_write(32'h00, 32'h10, 4'hF);
    bus_read(32'h04, 32'd0, "collide_hi");
    bus_read(32'h00, 32'h11, "collide_lo");
    bus_write(32'h10, 32'd0, 4'hF);

    // 64-bit wrap to zero
    bus_write(32'h00, 32'hFFFF_FFFF, 4'hF);
    bus_write(32'h04, 32'hFFFF_FFFF, 4'hF);
    bus_write(32'h10, 32'd1, 4'hF);
    bus_write(32'h10, 32'd0, 4'hF);
    bus_read(32'h04, 32'd0, "wrap_hi");
    bus_read(32'h00, 32'd0, "wrap_lo");
    check_eq("wrap_irq", 64'(irq_timer), 64'd0);

    // Byte enables and ignored writes
    bus_write(32'h08, 32'hFFFF_FFFF, 4'hF);
    bus_write(32'h08, 32'hAABB_CCDD, 4'b0101);
    bus_read(32'h08, 32'hFFBB_FFDD, "byte_en");
    bus_write(32'h18, 32'h1234_5678, 4'hF);
    bus_write(32'h10, 32'hFFFF_FFFE, 4'hF);
    bus_read(32'h10, 32'd0, "ctrl_rsvd");

    // Back-to-back reads with stb held
    bus.cyc = 1'b1;
    bus.stb = 1'b1;
    bus.we  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.adr = burst_adr[i];
      @(posedge clk);
      #1;
      check_eq("burst_ack", 64'(bus.ack), 64'd1);
      check_eq("burst_stall", 64'(bus.stall), 64'd0);
      check_eq("burst_data", 64'(bus.dat_s), 64'(burst_exp[i]));
    end
    bus_idle();
    @(posedge clk);
    #1;
    check_eq("burst_end_ack", 64'(bus.ack), 64'd0);

    // stb without cyc is not a request
    bus.stb = 1'b1;
    bus.adr = 32'h08;
    @(posedge clk);
    #1;
    bus_idle();
    check_eq("no_cyc_ack", 64'(bus.ack), 64'd0);

    // Reset while a request is being accepted
    bus_write(32'h14, 32'd5, 4'hF);
    bus_write(32'h10, 32'd1, 4'hF);
    bus_write(32'h08, 32'd0, 4'hF);
    @(posedge clk);
    #1;
    check_eq("pre_rst_irq", 64'(irq_timer), 64'd1);
    bus.cyc = 1'b1;
    bus.stb = 1'b1;
    bus.adr = 32'h14;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    bus_idle();
    rst_n = 1'b1;
    check_eq("rst_drop_ack", 64'(bus.ack), 64'd0);
    check_eq("rst_drop_irq", 64'(irq_timer), 64'd0);
    check_eq("rst_drop_dat", 64'(bus.dat_s), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    read_reset_values();
    check_eq("post_rst_irq", 64'(irq_timer), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
